// File: rtl/alu_ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings, default
// datapath width and the stage occupancy states.
package alu_ex_stage_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OP_WIDTH   = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SLTU = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_t;

    // Occupancy of the {main, skid} pair; (main empty, skid full) cannot occur.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } stage_state_t;

endpackage

// File: rtl/alu_ex_stage_alu.sv
// Combinational ALU. CarryOut is the raw adder carry (A + ~B + 1 for SUB, so
// 1 means no borrow); Overflow/CarryOut are driven only for ADD and SUB.
module alu_ex_stage_alu
    import alu_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [ALU_OP_WIDTH-1:0] ALUop,
    output logic [DATA_WIDTH-1:0]   Result,
    output logic                    Zero,
    output logic                    Overflow,
    output logic                    CarryOut
);

    logic                  do_sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry;
    logic                  ovf;

    // One shared adder serves ADD, SUB and both set-less-than compares.
    always_comb begin
        do_sub = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
        b_eff  = do_sub ? ~B : B;
        {carry, sum} = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, do_sub};
        ovf = (A[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
              (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_NOR:  Result = ~(A | B);
            OP_ADD, OP_SUB: begin
                Result   = sum;
                Overflow = ovf;
                CarryOut = carry;
            end
            OP_SLTU: Result = {{(DATA_WIDTH-1){1'b0}}, ~carry};
            OP_SLT:  Result = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ ovf};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered execute stage with a two-entry skid buffer and registered in_ready.
// Optional perf counters (perf_ops, perf_ovf) are enabled by defining ALU_EX_PERF_EN.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int DEST_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_A,
    input  logic [DATA_WIDTH-1:0]   in_B,
    input  logic [ALU_OP_WIDTH-1:0] in_ALUop,
    input  logic [DEST_WIDTH-1:0]   in_wdest,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_Result,
    output logic                    out_Zero,
    output logic                    out_Overflow,
    output logic                    out_CarryOut,
    output logic [DEST_WIDTH-1:0]   out_wdest
`ifdef ALU_EX_PERF_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_ovf
`endif
);

    localparam int BW = DATA_WIDTH + 3 + DEST_WIDTH;

    stage_state_t          state, state_nxt;
    logic                  in_ready_q;
    logic [BW-1:0]         main_q, skid_q, in_bundle;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero, alu_ovf, alu_carry;
    logic                  accept, fire;
    logic                  load_main_in, load_main_skid, load_skid;

    alu_ex_stage_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .A        (in_A),
        .B        (in_B),
        .ALUop    (in_ALUop),
        .Result   (alu_result),
        .Zero     (alu_zero),
        .Overflow (alu_ovf),
        .CarryOut (alu_carry)
    );

    assign in_bundle = {alu_result, alu_zero, alu_ovf, alu_carry, in_wdest};
    assign accept    = in_valid && in_ready_q;
    assign fire      = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != S_EMPTY);
    assign {out_Result, out_Zero, out_Overflow, out_CarryOut, out_wdest} = main_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && fire) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = S_FULL;
                end else if (fire) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // in_ready is the registered complement of the next cycle's skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_bundle;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_bundle;
        end
    end

`ifdef ALU_EX_PERF_EN
    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops <= '0;
            perf_ovf <= '0;
        end else if (accept) begin
            if (perf_ops != 32'hFFFF_FFFF)
                perf_ops <= perf_ops + 32'd1;
            if (((in_ALUop == OP_ADD) || (in_ALUop == OP_SUB)) && alu_ovf &&
                (perf_ovf != 32'hFFFF_FFFF))
                perf_ovf <= perf_ovf + 32'd1;
        end
    end
`endif

endmodule
